// File: rtl/csr_file.sv
// csr_file: RV32 M-mode CSR file with 64-bit counters, trap/mret and irq arbitration.
// Optional: define CSR_VECTORED_EN for a writable mtvec.MODE (vectored interrupts).
module csr_file #(
  parameter int unsigned NUM_HPM     = 4,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] addr_i,
  input  logic [4:0]  rs1_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        illegal_o,
  input  logic        retire_i,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  output logic        irq_pending_o,
  output logic [31:0] irq_cause_o,
  output logic [31:0] target_pc_o
);

  localparam int unsigned NUM_CNT = 3 + NUM_HPM;
  localparam logic [31:0] CNT_MASK =
    32'((64'd1 << NUM_CNT) - 64'd1) & ~32'h2;
  localparam logic [31:0] MTVEC_RST = {MTVEC_RESET[31:2], 2'b00};

  logic        st_mie, st_mpie;
  logic [31:0] misa_q, medeleg_q, mideleg_q, mie_q, mtvec_q;
  logic [31:0] mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] minh_q, mip_q;
  logic [63:0] cnt_q [32];

  logic        hit, cnt_lo, cnt_hi, set_src, wr_req, we;
  logic [4:0]  cidx;
  logic [31:0] rdata, wdata, inc, pend, base_pc, vec_pc;

  assign cidx   = addr_i[4:0];
  assign cnt_lo = (addr_i[11:5] == 7'h58) && CNT_MASK[cidx];
  assign cnt_hi = (addr_i[11:5] == 7'h5C) && CNT_MASK[cidx];

  always_comb begin
    hit   = 1'b1;
    rdata = '0;
    case (addr_i)
      12'h300: rdata = {19'b0, 2'b11, 3'b0, st_mpie,
                        3'b0, st_mie, 3'b0};
      12'h301: rdata = misa_q;
      12'h302: rdata = medeleg_q;
      12'h303: rdata = mideleg_q;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h320: rdata = minh_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_q;
      12'hF11, 12'hF12, 12'hF13: rdata = '0;
      12'hF14: rdata = HART_ID;
      default: begin
        if (cnt_lo)      rdata = cnt_q[cidx][31:0];
        else if (cnt_hi) rdata = cnt_q[cidx][63:32];
        else             hit   = 1'b0;
      end
    endcase
  end

  assign set_src = funct3_i[2] ? (data_i != '0) : (rs1_i != '0);
  assign wr_req  = csr_valid_i &
                   ((funct3_i[1:0] == 2'b01) | (funct3_i[1] & set_src));
  assign illegal_o = csr_valid_i &
                     (~hit | (wr_req & (addr_i[11:10] == 2'b11)));
  assign we     = wr_req & ~illegal_o;
  assign data_o = (csr_valid_i & ~illegal_o) ? rdata : '0;

  always_comb begin
    unique case (funct3_i[1:0])
      2'b01:   wdata = data_i;
      2'b10:   wdata = rdata | data_i;
      2'b11:   wdata = rdata & ~data_i;
      default: wdata = rdata;
    endcase
  end

  always_comb begin
    inc    = '0;
    inc[0] = 1'b1;
    inc[2] = retire_i;
    for (int k = 0; k < int'(NUM_HPM); k++) inc[k+3] = hpm_event_i[k];
    inc = inc & ~minh_q & CNT_MASK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 32; n++) begin
        if (!CNT_MASK[n]) begin
          cnt_q[n] <= '0;
        end else if (we && (cnt_lo || cnt_hi) && cidx == 5'(n)) begin
          if (addr_i[7]) cnt_q[n][63:32] <= wdata;
          else           cnt_q[n][31:0]  <= wdata;
        end else if (inc[n]) begin
          cnt_q[n] <= cnt_q[n] + 64'd1;
        end
      end
    end
  end

  // trap beats mret beats CSR write: later non-blocking assignments win
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      misa_q     <= '0;
      medeleg_q  <= '0;
      mideleg_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      minh_q     <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= {20'b0, irq_ext_i, 3'b0, irq_timer_i,
                3'b0, irq_sw_i, 3'b0};
      if (we) begin
        case (addr_i)
          12'h300: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          12'h301: misa_q     <= wdata;
          12'h302: medeleg_q  <= wdata;
          12'h303: mideleg_q  <= wdata;
          12'h304: mie_q      <= wdata & 32'h0000_0888;
`ifdef CSR_VECTORED_EN
          12'h305: mtvec_q    <= {wdata[31:2], 1'b0, wdata[0]};
`else
          12'h305: mtvec_q    <= {wdata[31:2], 2'b00};
`endif
          12'h320: minh_q     <= wdata;
          12'h340: mscratch_q <= wdata;
          12'h341: mepc_q     <= {wdata[31:2], 2'b00};
          12'h342: mcause_q   <= wdata;
          12'h343: mtval_q    <= wdata;
          default: ;
        endcase
      end
      if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      if (trap_i) begin
        mepc_q   <= {trap_pc_i[31:2], 2'b00};
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end
    end
  end

  assign pend          = mip_q & mie_q;
  assign irq_pending_o = st_mie & (|pend);

  always_comb begin
    irq_cause_o = '0;
    if (st_mie) begin
      if (pend[11])     irq_cause_o = 32'h8000_000B;
      else if (pend[3]) irq_cause_o = 32'h8000_0003;
      else if (pend[7]) irq_cause_o = 32'h8000_0007;
    end
  end

  assign base_pc = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
  assign vec_pc = (mtvec_q[0] && trap_cause_i[31])
                ? base_pc + {25'b0, trap_cause_i[4:0], 2'b00}
                : base_pc;
`else
  assign vec_pc = base_pc;
`endif
  assign target_pc_o = mret_i ? mepc_q : vec_pc;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scenarios plus random traffic for csr_file,
// scored against an address-map level model of the CSR state.
module tb_csr_file;

  localparam int          NH  = 4;
  localparam logic [31:0] HID = 32'hC0DE_0007;
  localparam logic [31:0] MTR = 32'h0000_0103;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_valid_i;
  logic [2:0]  funct3_i;
  logic [11:0] addr_i;
  logic [4:0]  rs1_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        illegal_o;
  logic        retire_i;
  logic [NH-1:0] hpm_event_i;
  logic        trap_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_val_i;
  logic        mret_i, irq_ext_i, irq_timer_i, irq_sw_i;
  logic        irq_pending_o;
  logic [31:0] irq_cause_o, target_pc_o;

  csr_file #(.NUM_HPM(NH), .HART_ID(HID), .MTVEC_RESET(MTR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_valid_i(csr_valid_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .rs1_i(rs1_i),
    .data_i(data_i), .data_o(data_o), .illegal_o(illegal_o),
    .retire_i(retire_i), .hpm_event_i(hpm_event_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i),
    .mret_i(mret_i), .irq_ext_i(irq_ext_i),
    .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
    .irq_pending_o(irq_pending_o), .irq_cause_o(irq_cause_o),
    .target_pc_o(target_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // model state: address-keyed plain registers and 64-bit counters
  bit          m_ie, m_pie;
  bit [31:0]   m_mip;
  bit [31:0]   m_csr [bit [11:0]];
  bit [63:0]   m_cnt [int];

  task automatic model_reset();
    bit [11:0] rw [10] = '{12'h301, 12'h302, 12'h303, 12'h304, 12'h320,
                           12'h340, 12'h341, 12'h342, 12'h343, 12'h305};
    m_ie  = 0;
    m_pie = 0;
    m_mip = 0;
    foreach (rw[i]) m_csr[rw[i]] = 32'h0;
    m_csr[12'h305] = MTR & ~32'h3;
    m_cnt.delete();
    m_cnt[0] = 0;
    m_cnt[2] = 0;
    for (int k = 3; k < 3 + NH; k++) m_cnt[k] = 0;
  endtask

  function automatic bit is_cnt_addr(input bit [11:0] a);
    return (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
  endfunction

  function automatic bit m_read(input bit [11:0] a, output bit [31:0] v);
    int n;
    v = '0;
    n = int'(a[4:0]);
    if (a == 12'h300) begin
      v = 32'h1800 | (32'(m_pie) << 7) | (32'(m_ie) << 3);
      return 1;
    end
    if (m_csr.exists(a)) begin v = m_csr[a]; return 1; end
    if (a == 12'h344) begin v = m_mip; return 1; end
    if (a >= 12'hF11 && a <= 12'hF13) return 1;
    if (a == 12'hF14) begin v = HID; return 1; end
    if (is_cnt_addr(a)) begin
      if (!m_cnt.exists(n)) return 0;
      v = (a >= 12'hB80) ? m_cnt[n][63:32] : m_cnt[n][31:0];
      return 1;
    end
    return 0;
  endfunction

  // check all outputs against the model, then advance the model over one edge
  task automatic tick();
    bit ok, wa, ill, pend, oi, op, wr;
    bit [31:0] v, nv, p, ecause, ed, etgt;
    int n;
    #1;
    ok   = m_read(addr_i, v);
    wa   = (funct3_i[1:0] == 2'b01) ||
           (funct3_i[1] && (funct3_i[2] ? data_i != 0 : rs1_i != 0));
    ill  = csr_valid_i && (!ok || (wa && addr_i[11:10] == 2'b11));
    ed   = (csr_valid_i && !ill) ? v : 32'h0;
    p    = m_mip & m_csr[12'h304];
    pend = m_ie && (p != 0);
    ecause = !pend ? 32'h0 : p[11] ? 32'h8000_000B :
             p[3] ? 32'h8000_0003 : 32'h8000_0007;
    etgt = mret_i ? m_csr[12'h341] : (m_csr[12'h305] & ~32'h3);
    check("data_o", data_o, ed);
    check("illegal_o", illegal_o, ill);
    check("irq_pending_o", irq_pending_o, pend);
    check("irq_cause_o", irq_cause_o, ecause);
    check("target_pc_o", target_pc_o, etgt);
    @(posedge clk_i);
    oi = m_ie;
    op = m_pie;
    case (funct3_i[1:0])
      2'b01:   nv = data_i;
      2'b10:   nv = v | data_i;
      2'b11:   nv = v & ~data_i;
      default: nv = v;
    endcase
    wr = csr_valid_i && !ill && wa;
    n  = int'(addr_i[4:0]);
    foreach (m_cnt[k]) begin
      if (wr && is_cnt_addr(addr_i) && k == n)
        m_cnt[k] = addr_i[7] ? {nv, m_cnt[k][31:0]} : {m_cnt[k][63:32], nv};
      else if (!m_csr[12'h320][k] &&
               (k == 0 || (k == 2 && retire_i) ||
                (k >= 3 && hpm_event_i[k-3])))
        m_cnt[k] = m_cnt[k] + 64'd1;
    end
    if (wr && !is_cnt_addr(addr_i)) begin
      case (addr_i)
        12'h300: begin m_ie = nv[3]; m_pie = nv[7]; end
        12'h304: m_csr[addr_i] = nv & 32'h888;
        12'h305, 12'h341: m_csr[addr_i] = nv & ~32'h3;
        default: if (m_csr.exists(addr_i)) m_csr[addr_i] = nv;
      endcase
    end
    if (mret_i && !trap_i) begin m_ie = op; m_pie = 1; end
    if (trap_i) begin
      m_csr[12'h341] = trap_pc_i & ~32'h3;
      m_csr[12'h342] = trap_cause_i;
      m_csr[12'h343] = trap_val_i;
      m_pie = oi;
      m_ie  = 0;
    end
    m_mip = (32'(irq_ext_i) << 11) | (32'(irq_timer_i) << 7) |
            (32'(irq_sw_i) << 3);
    @(negedge clk_i);
  endtask

  task automatic drive(bit v, bit [2:0] f, bit [11:0] a,
                       bit [4:0] r, bit [31:0] d);
    csr_valid_i = v; funct3_i = f; addr_i = a; rs1_i = r; data_i = d;
  endtask

  bit [11:0] alist [22] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304,
    12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
    12'hF11, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03,
    12'hB86, 12'hB07, 12'hB01};

  initial begin
    rst_i = 1;
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0);
    retire_i = 0; hpm_event_i = '0; trap_i = 0; mret_i = 0;
    trap_cause_i = 0; trap_pc_i = 0; trap_val_i = 0;
    irq_ext_i = 0; irq_timer_i = 0; irq_sw_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst data_o", data_o, 32'h0);
    check("rst illegal_o", illegal_o, 1'b0);
    check("rst irq_pending_o", irq_pending_o, 1'b0);
    check("rst irq_cause_o", irq_cause_o, 32'h0);
    check("rst target_pc_o", target_pc_o, 32'h100);
    @(negedge clk_i);
    rst_i = 0;
    model_reset();

    drive(1, 3'b010, 12'h300, 5'd0, 32'h0);
    #1 check("mstatus reset", data_o, 32'h1800);
    tick();
    drive(1, 3'b010, 12'hF14, 5'd0, 32'h0);
    #1 check("mhartid", data_o, HID);
    check("mhartid illegal", illegal_o, 1'b0);
    tick();

    drive(1, 3'b001, 12'h340, 5'd5, 32'h55); tick();
    drive(1, 3'b010, 12'h340, 5'd0, 32'hFF);
    #1 check("csrrs x0 mscratch", data_o, 32'h55);
    tick();
    drive(1, 3'b011, 12'h340, 5'd1, 32'h05); tick();
    drive(1, 3'b010, 12'h340, 5'd0, 32'h0);
    #1 check("csrrc mscratch", data_o, 32'h50);
    tick();

    drive(1, 3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF); tick();
    drive(1, 3'b001, 12'hB80, 5'd1, 32'h0); tick();
    drive(1, 3'b010, 12'hB00, 5'd0, 32'h0);
    #1 check("mcycle lo pre", data_o, 32'hFFFF_FFFF);
    tick();
    drive(1, 3'b010, 12'hB80, 5'd0, 32'h0);
    #1 check("mcycle hi carry", data_o, 32'h1);
    tick();
    drive(1, 3'b010, 12'hB00, 5'd0, 32'h0);
    #1 check("mcycle lo wrap", data_o, 32'h1);
    tick();

    drive(1, 3'b001, 12'h320, 5'd1, 32'h4); tick();
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0);
    retire_i = 1;
    repeat (3) tick();
    retire_i = 0;
    drive(1, 3'b010, 12'hB02, 5'd0, 32'h0);
    #1 check("minstret inhibited", data_o, 32'h0);
    tick();
    drive(1, 3'b001, 12'h320, 5'd1, 32'h0); tick();
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0);
    retire_i = 1;
    repeat (3) tick();
    retire_i = 0;
    drive(1, 3'b010, 12'hB02, 5'd0, 32'h0);
    #1 check("minstret counted", data_o, 32'h3);
    tick();

    drive(1, 3'b001, 12'h300, 5'd1, 32'h8); tick();
    drive(1, 3'b001, 12'h304, 5'd1, 32'h888); tick();
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0);
    irq_timer_i = 1; irq_ext_i = 1;
    tick();
    #1 check("irq cause MEI", irq_cause_o, 32'h8000_000B);
    check("irq pending", irq_pending_o, 1'b1);
    tick();
    trap_i = 1; trap_pc_i = 32'h100; trap_cause_i = 32'h8000_000B;
    trap_val_i = 32'h0;
    tick();
    trap_i = 0;
    drive(1, 3'b010, 12'h341, 5'd0, 32'h0);
    #1 check("mepc after trap", data_o, 32'h100);
    tick();
    drive(1, 3'b010, 12'h300, 5'd0, 32'h0);
    #1 check("mstatus after trap", data_o, 32'h1880);
    tick();
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0);
    mret_i = 1;
    #1 check("mret target", target_pc_o, 32'h100);
    tick();
    mret_i = 0;
    drive(1, 3'b010, 12'h300, 5'd0, 32'h0);
    #1 check("mstatus after mret", data_o, 32'h1888);
    tick();
    irq_timer_i = 0; irq_ext_i = 0;

    drive(1, 3'b001, 12'hF11, 5'd1, 32'h5);
    #1 check("write 0xF11 illegal", illegal_o, 1'b1);
    tick();
    drive(1, 3'b010, 12'hB00 + 12'(3 + NH), 5'd0, 32'h0);
    #1 check("hpm past end illegal", illegal_o, 1'b1);
    tick();

    drive(1, 3'b001, 12'h342, 5'd1, 32'h1234);
    trap_i = 1; trap_cause_i = 32'h5; trap_pc_i = 32'h203;
    tick();
    trap_i = 0;
    drive(1, 3'b010, 12'h342, 5'd0, 32'h0);
    #1 check("trap beats csrrw mcause", data_o, 32'h5);
    tick();

    drive(1, 3'b001, 12'h340, 5'd1, 32'hAA);
    #2 rst_i = 1;
    #1 check("async reset mscratch", data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    drive(1, 3'b010, 12'h340, 5'd0, 32'h0);
    #1 check("write dropped by reset", data_o, 32'h0);
    tick();

    for (int i = 0; i < 1500; i++) begin
      csr_valid_i = ($urandom_range(0, 3) != 0);
      funct3_i    = 3'($urandom);
      addr_i      = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                  : alist[$urandom_range(0, 21)];
      rs1_i       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (funct3_i[2]) data_i = 32'($urandom_range(0, 31));
      else data_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      retire_i     = 1'($urandom);
      hpm_event_i  = NH'($urandom);
      trap_i       = ($urandom_range(0, 15) == 0);
      mret_i       = ($urandom_range(0, 15) == 0);
      trap_cause_i = $urandom;
      trap_pc_i    = $urandom;
      trap_val_i   = $urandom;
      irq_ext_i    = 1'($urandom);
      irq_timer_i  = 1'($urandom);
      irq_sw_i     = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
